modular_square_ggg_normalize: RTL and testbench



---
 rtl/ggg_pkg.sv | 27 ++
 rtl/ggg_carry_pass.sv | 41 ++++
 rtl/modular_square_ggg_normalize.sv | 108 ++++++++++
 tb/tb_modular_square_ggg_normalize.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ggg_pkg.sv
// Shared constants and types for the modular_square GGG result normaliser.
package ggg_pkg;

  localparam int NUM_ELEMENTS = 21;
  localparam int BIT_LEN      = 51;
  localparam int WORD_LEN     = 50;
  localparam int TOP_BITS     = 21;
  localparam int PASS_W       = $clog2(NUM_ELEMENTS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROPAGATE,
    ST_DONE
  } state_t;

  typedef logic [BIT_LEN-1:0]  red_elem_t;
  typedef logic [WORD_LEN-1:0] norm_elem_t;
  typedef red_elem_t  [NUM_ELEMENTS-1:0] red_vec_t;
  typedef norm_elem_t [NUM_ELEMENTS-1:0] norm_vec_t;
  typedef logic [PASS_W-1:0] pass_cnt_t;

  // Strip the carry bit of a redundant element, keeping the redundant width.
  function automatic red_elem_t low_word(input red_elem_t e);
    return {1'b0, e[WORD_LEN-1:0]};
  endfunction

endpackage

// File: rtl/ggg_carry_pass.sv
// One combinational carry-ripple pass over the redundant working value.
// carry_any_o exists only when GGG_NORM_EARLY_EXIT_EN is defined.
module ggg_carry_pass
  import ggg_pkg::*;
(
  input  red_vec_t w_i,
  output red_vec_t w_o,
`ifdef GGG_NORM_EARLY_EXIT_EN
  output logic     carry_any_o,
`endif
  output logic     overflow_o
);

  logic [NUM_ELEMENTS-2:0] carry;

  always_comb begin
    carry = '0;
    for (int k = 0; k < NUM_ELEMENTS - 1; k++) begin
      carry[k] = w_i[k][WORD_LEN];
    end
  end

  // Bits above the legal top width are discarded; their presence is the overflow.
  assign overflow_o = |w_i[NUM_ELEMENTS-1][BIT_LEN-1:TOP_BITS];

  always_comb begin
    // NOTE: assign a default to every always_comb output before any branch or loop so no path leaves it unassigned and a latch is inferred.
    w_o    = '0;
    w_o[0] = low_word(w_i[0]);
    for (int k = 1; k < NUM_ELEMENTS - 1; k++) begin
      w_o[k] = low_word(w_i[k]) + red_elem_t'(carry[k-1]);
    end
    w_o[NUM_ELEMENTS-1] = red_elem_t'(w_i[NUM_ELEMENTS-1][TOP_BITS-1:0])
                        + red_elem_t'(carry[NUM_ELEMENTS-2]);
  end

`ifdef GGG_NORM_EARLY_EXIT_EN
  assign carry_any_o = (|carry) | overflow_o;
`endif

endmodule

// File: rtl/modular_square_ggg_normalize.sv
// Multi-cycle carry normaliser for the 21-element redundant square result.
// GGG_NORM_EARLY_EXIT_EN selects data-dependent exit; otherwise a fixed 21-pass latency.
module modular_square_ggg_normalize
  import ggg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  red_vec_t   in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output norm_vec_t  out_data,
  output pass_cnt_t  out_passes,
  output logic       out_overflow
);

  state_t    state_q, state_d;
  red_vec_t  w_q, w_d;
  pass_cnt_t cnt_q, cnt_d;
  logic      ov_q, ov_d;

  red_vec_t  w_pass;
  logic      pass_ov;
`ifdef GGG_NORM_EARLY_EXIT_EN
  logic      carry_any;
`endif

  ggg_carry_pass u_carry_pass (
    .w_i         (w_q),
    .w_o         (w_pass),
`ifdef GGG_NORM_EARLY_EXIT_EN
    .carry_any_o (carry_any),
`endif
    .overflow_o  (pass_ov)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          w_d     = in_data;
          cnt_d   = '0;
          ov_d    = 1'b0;
          state_d = ST_PROPAGATE;
        end
      end
      ST_PROPAGATE: begin
`ifdef GGG_NORM_EARLY_EXIT_EN
        if (!carry_any || cnt_q == pass_cnt_t'(NUM_ELEMENTS)) begin
          state_d = ST_DONE;
        end else begin
          w_d   = w_pass;
          cnt_d = cnt_q + pass_cnt_t'(1);
          ov_d  = ov_q | pass_ov;
        end
`else
        // The final pass is applied on the same edge that enters DONE.
        w_d   = w_pass;
        cnt_d = cnt_q + pass_cnt_t'(1);
        ov_d  = ov_q | pass_ov;
        if (cnt_q == pass_cnt_t'(NUM_ELEMENTS - 1)) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of process order.
    if (reset) begin
      state_q <= ST_IDLE;
      // NOTE: the working register is reset, not left uninitialised, because out_data must read zero straight after reset.
      w_q     <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign out_passes   = cnt_q;
  assign out_overflow = ov_q;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      out_data[k] = w_q[k][WORD_LEN-1:0];
    end
  end

endmodule

// File: tb/tb_modular_square_ggg_normalize.sv
// Self-checking bench: big-integer reference model plus directed vectors for the GGG normaliser.
module tb_modular_square_ggg_normalize;
  import ggg_pkg::*;

  localparam int BIGW = 1100;
  localparam int LIMIT_BIT = WORD_LEN * (NUM_ELEMENTS - 1) + TOP_BITS;

  typedef struct {
    norm_vec_t data;
    pass_cnt_t passes;
    logic      ov;
    int        lat;
  } exp_t;

  logic      clk;
  logic      reset;
  logic      in_valid;
  logic      in_ready;
  red_vec_t  in_data;
  logic      out_valid;
  logic      out_ready;
  norm_vec_t out_data;
  pass_cnt_t out_passes;
  logic      out_overflow;

  int n_checks = 0;
  int n_err    = 0;
  exp_t exp_q[$];

  modular_square_ggg_normalize dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_passes   (out_passes),
    .out_overflow (out_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input norm_vec_t act, input norm_vec_t exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int k = NUM_ELEMENTS - 1; k >= 0; k--) begin
      if (act[k] !== exp[k]) bad = k;
    end
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s word %0d: got %0h required %0h", name, bad, act[bad], exp[bad]);
    end
  endtask

  // Reference: the normalised result is the integer value of the redundant input,
  // reduced below 2^LIMIT_BIT; overflow means the value did not fit.
  function automatic exp_t model(input red_vec_t w, input int p_early);
    logic [BIGW-1:0] v;
    exp_t e;
    v = '0;
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      v = v + (BIGW'(w[k]) << (WORD_LEN * k));
    end
    for (int k = 0; k < NUM_ELEMENTS - 1; k++) begin
      e.data[k] = v[WORD_LEN*k +: WORD_LEN];
    end
    e.data[NUM_ELEMENTS-1] = WORD_LEN'(v[WORD_LEN*(NUM_ELEMENTS-1) +: TOP_BITS]);
    e.ov = |v[BIGW-1:LIMIT_BIT];
`ifdef GGG_NORM_EARLY_EXIT_EN
    e.passes = pass_cnt_t'(p_early);
    e.lat    = p_early + 2;
`else
    e.passes = pass_cnt_t'(NUM_ELEMENTS);
    e.lat    = NUM_ELEMENTS + 1;
`endif
    return e;
  endfunction

  // Compare process: samples on the falling edge, while inputs and outputs are stable.
  initial begin : monitor
    exp_t cur;
    bit   busy;
    bit   seen;
    bit   idle_next;
    int   cyc;
    busy = 0; seen = 0; idle_next = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0; seen = 0; idle_next = 0;
        exp_q.delete();
        continue;
      end
      if (idle_next) begin
        check("in_ready after handshake", 64'(in_ready), 64'd1);
        check("out_valid after handshake", 64'(out_valid), 64'd0);
        idle_next = 0;
      end
      if (busy) cyc++;
      if (out_valid) begin
        if (!busy) begin
          check("out_valid with nothing in flight", 64'(out_valid), 64'd0);
        end else begin
          if (!seen) begin
            check("latency", 64'(cyc), 64'(cur.lat));
            seen = 1;
          end
          check_vec("out_data", out_data, cur.data);
          check("out_passes", 64'(out_passes), 64'(cur.passes));
          check("out_overflow", 64'(out_overflow), 64'(cur.ov));
          check("in_ready in DONE", 64'(in_ready), 64'd0);
          if (out_ready) begin
            busy = 0;
            idle_next = 1;
          end
        end
      end else if (busy && cyc > cur.lat + 2) begin
        n_checks++;
        n_err++;
        $display("FAIL out_valid timeout: got none after %0d cycles required at %0d", cyc, cur.lat);
        busy = 0;
      end
      if (in_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL accept: got an unexpected accept required none");
        end else begin
          cur  = exp_q.pop_front();
          busy = 1; seen = 0; cyc = 0;
        end
      end
    end
  end

  task automatic run_item(input red_vec_t v, input int p_early, input int stall,
                          output norm_vec_t got_data, output logic got_ov);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    exp_q.push_back(model(v, p_early));
    in_valid  = 1'b1;
    in_data   = v;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid reached", 64'(out_valid), 64'd1);
    got_data = out_data;
    got_ov   = out_overflow;
    for (int i = 0; i < stall; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = ~v;
      @(posedge clk); #1;
      check("out_valid held in stall", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : driver
    red_vec_t  v_norm, v_one, v_worst, v_top, v_multi, v_ripov;
    norm_vec_t got;
    logic      gov;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check_vec("reset out_data", out_data, '0);
    check("reset out_passes", 64'(out_passes), 64'd0);
    check("reset out_overflow", 64'(out_overflow), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < NUM_ELEMENTS - 1; k++) begin
      v_norm[k] = {1'b0, 50'(64'h0123_4567_89AB_CDEF * (k + 3))};
    end
    v_norm[NUM_ELEMENTS-1] = {30'd0, 21'h1A_BCDE};

    v_one = '0;
    v_one[0] = {1'b1, 50'd0};
    v_one[1] = 51'd5;

    v_worst = '0;
    v_worst[0] = {1'b1, 50'd0};
    for (int k = 1; k < NUM_ELEMENTS - 1; k++) v_worst[k] = {1'b0, {50{1'b1}}};

    v_top = '0;
    v_top[NUM_ELEMENTS-1] = 51'(32'h0020_0007);

    v_multi = '0;
    v_multi[0] = {1'b1, 50'd3};
    v_multi[5] = {51{1'b1}};

    v_ripov = '0;
    v_ripov[NUM_ELEMENTS-2] = {1'b1, 50'd0};
    v_ripov[NUM_ELEMENTS-1] = 51'(32'h001F_FFFF);

    run_item(v_norm, 0, 0, got, gov);
    check("normal word0 passthrough", 64'(got[0]), 64'(v_norm[0][49:0]));

    run_item(v_one, 1, 0, got, gov);
    check("single carry word0", 64'(got[0]), 64'd0);
    check("single carry word1", 64'(got[1]), 64'd6);

    run_item(v_worst, 20, 0, got, gov);
    check("worst ripple word19", 64'(got[19]), 64'd0);
    check("worst ripple word20", 64'(got[20]), 64'd1);

    run_item(v_top, 1, 0, got, gov);
    check("top overflow word20", 64'(got[20]), 64'd7);
    check("top overflow flag", 64'(gov), 64'd1);

    run_item(v_one, 1, 0, got, gov);
    check("overflow cleared", 64'(gov), 64'd0);

    run_item(v_multi, 1, 0, got, gov);
    check("multi carry word6", 64'(got[6]), 64'd1);

    run_item(v_ripov, 2, 0, got, gov);
    check("ripple overflow word20", 64'(got[20]), 64'd0);
    check("ripple overflow flag", 64'(gov), 64'd1);

    run_item(v_one, 1, 5, got, gov);

    // Reset during PROPAGATE cycle 4 abandons the value.
    exp_q.push_back(model(v_worst, 20));
    in_valid = 1'b1;
    in_data  = v_worst;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid reset in_ready", 64'(in_ready), 64'd1);
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset out_passes", 64'(out_passes), 64'd0);
    repeat (25) begin
      @(posedge clk); #1;
      check("no out_valid after mid reset", 64'(out_valid), 64'd0);
    end

    run_item(v_multi, 1, 0, got, gov);
    check("post reset word0", 64'(got[0]), 64'd3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
